mem_access_unit: RTL and testbench

//  MEM-stage load/store initiator driving the 64x32 single-port DataRAM (async read, sync word write).

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/lsu_lane_logic.sv | 42 ++++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 tb/tb_mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store unit.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_e;

    // One bit per byte lane touched by an access of the given size/offset.
    function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        case (size)
            SZ_B:    s = 4'b0001 << off;
            SZ_H:    s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            SZ_B:    r = {{24{b[7] & ~uns}}, b};
            SZ_H:    r = {{16{h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_logic.sv
// Combinational lane datapath: load extract/extend, sub-word store merge, misalign detect.
module lsu_lane_logic
    import mem_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [1:0]  cap_size_i,
    input  logic [1:0]  cap_off_i,
    input  logic        cap_uns_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o,
    output logic        misalign_o
);

    logic [3:0]  sel;
    logic [31:0] wrep;

    assign sel = lane_sel(cap_size_i, cap_off_i);

    // Replicate the store lane so every candidate byte position already holds the right data.
    assign wrep = (cap_size_i == SZ_B) ? {4{wdata_i[7:0]}} :
                  (cap_size_i == SZ_H) ? {2{wdata_i[15:0]}} : wdata_i;

    assign load_data_o = load_extend(rd_word_i, cap_size_i, cap_off_i, cap_uns_i);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merge_data_o[8*i +: 8] = sel[i] ? wrep[8*i +: 8] : old_word_i[8*i +: 8];
    end

    always_comb begin
        case (req_size_i)
            SZ_B:    misalign_o = 1'b0;
            SZ_H:    misalign_o = req_off_i[0];
            SZ_W:    misalign_o = |req_off_i;
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a 64x32 async-read, sync-write DataRAM.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wea,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    state_e              state_q, state_d;
    logic                we_q, uns_q, err_q;
    logic [1:0]          size_q, off_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   data_q;   // load result, or old word for a sub-word store
    logic [DATA_W-1:0]   load_data, merge_data;
    logic                misalign, accept;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign accept         = (state_q == S_IDLE) && req_valid;
    assign ram_addr       = idx_q;

    lsu_lane_logic u_lane (
        .req_size_i   (req_size),
        .req_off_i    (req_addr[1:0]),
        .cap_size_i   (size_q),
        .cap_off_i    (off_q),
        .cap_uns_i    (uns_q),
        .rd_word_i    (ram_rd_data),
        .old_word_i   (data_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data),
        .misalign_o   (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Outputs are decoded from the state so an async reset kills ram_wea immediately.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        ram_wea     = 1'b0;
        ram_wr_data = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = misalign ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (we_q && size_q != SZ_W) begin
                    state_d = S_MERGE;
                end else begin
                    state_d = S_RESP;
                    if (we_q) begin
                        ram_wea     = 1'b1;
                        ram_wr_data = wdata_q;
                    end
                end
            end
            S_MERGE: begin
                ram_wea     = 1'b1;
                ram_wr_data = merge_data;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!we_q && !err_q) ? data_q : '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            idx_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= misalign;
                size_q  <= req_size;
                off_q   <= req_addr[1:0];
                idx_q   <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
            end
            if (state_q == S_ACCESS) data_q <= we_q ? ram_rd_data : load_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench: RAM model, per-cycle reference model checker, directed + random requests.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [5:0]  ram_addr;
    logic        ram_wea;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_rd_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_addr(ram_addr),
        .ram_wea(ram_wea), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    logic [31:0] ram [64] = '{default: 32'h0};
    assign ram_rd_data = ram[ram_addr];
    always @(posedge clk) if (ram_wea) ram[ram_addr] <= ram_wr_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (compare process owns all m_* state) ----------------
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    bit          m_busy = 0;
    int          m_cnt = 0;
    bit          m_we, m_err;
    logic [5:0]  m_idx;
    logic [31:0] m_rdata, m_new;
    int          n_acc = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_lat = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_ld = '0;
    bit          last_err = 0;
    bit          exp_ready, exp_resp, exp_wea;
    int          nb, sh;
    logic [31:0] v, mask, old;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_ready", {31'b0, req_ready}, 32'd1);
            chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
            chk("rst_err", {31'b0, resp_err}, 32'd0);
            chk("rst_wea", {31'b0, ram_wea}, 32'd0);
            chk("rst_wr_data", ram_wr_data, 32'd0);
            m_busy = 0;
        end else begin
            exp_ready = !m_busy;
            exp_resp  = 0;
            exp_wea   = 0;
            if (m_busy) begin
                m_cnt--;
                exp_resp = (m_cnt == 0);
                exp_wea  = m_we && !m_err && (m_cnt == 1);
            end
            chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp});
            chk("ram_wea", {31'b0, ram_wea}, {31'b0, exp_wea});
            if (exp_wea) begin
                chk("wr_addr", {26'b0, ram_addr}, {26'b0, m_idx});
                chk("wr_data", ram_wr_data, m_new);
            end
            if (exp_resp) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, m_err});
                if (m_we && !m_err) ref_mem[m_idx] = m_new;
                chk("mem_word", ram[m_idx], ref_mem[m_idx]);
                last_rdata = resp_rdata;
                last_err   = resp_err;
                if (!m_we) last_ld = resp_rdata;
                last_lat   = cyc - acc_cyc;
                m_busy     = 0;
            end
            if (exp_ready && req_valid) begin
                n_acc++;
                acc_cyc = cyc;
                m_busy  = 1;
                m_we    = req_we;
                m_idx   = req_addr[7:2];
                nb      = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                sh      = 8 * int'(req_addr[1:0]);
                m_err   = (req_size == 2'd3) || (nb == 2 && req_addr[0]) ||
                          (nb == 4 && req_addr[1:0] != 2'd0);
                old     = ref_mem[m_idx];
                m_rdata = '0;
                m_new   = old;
                if (m_err) begin
                    m_cnt = 1;
                end else if (!req_we) begin
                    m_cnt = 2;
                    v = old >> sh;
                    if (nb == 1) begin
                        v = v & 32'hFF;
                        if (!req_unsigned && v[7]) v = v | 32'hFFFF_FF00;
                    end else if (nb == 2) begin
                        v = v & 32'hFFFF;
                        if (!req_unsigned && v[15]) v = v | 32'hFFFF_0000;
                    end
                    m_rdata = v;
                end else begin
                    m_cnt = (nb == 4) ? 2 : 3;
                    mask  = (nb == 4) ? 32'hFFFF_FFFF : (nb == 2) ? (32'hFFFF << sh) : (32'hFF << sh);
                    m_new = (old & ~mask) | ((req_wdata << sh) & mask);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold);
        int start;
        start        = n_acc;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        for (int i = 0; i < 30 && n_acc == start; i++) @(posedge clk);
        if (n_acc == start) chk("accept_timeout", 32'd0, 32'd1);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && m_busy; i++) @(posedge clk);
        if (m_busy) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wd);
        do_req(we, sz, uns, addr, wd, 1'b0);
        wait_idle();
    endtask

    int start_acc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // word store then load
        op(1, 2'b10, 0, 32'h04, 32'hDEAD_BEEF);
        chk("sw_lat", last_lat, 2);
        op(0, 2'b10, 0, 32'h04, 0);
        chk("lw_val", last_rdata, 32'hDEAD_BEEF);
        chk("lw_lat", last_lat, 2);

        // byte read-modify-write
        op(1, 2'b10, 0, 32'h08, 32'h1122_3344);
        op(1, 2'b00, 0, 32'h0A, 32'h1234_56AA);
        chk("sb_lat", last_lat, 3);
        op(0, 2'b10, 0, 32'h08, 0);  chk("lw_after_sb", last_rdata, 32'h11AA_3344);
        op(0, 2'b00, 0, 32'h0A, 0);  chk("lb", last_rdata, 32'hFFFF_FFAA);
        op(0, 2'b00, 1, 32'h0A, 0);  chk("lbu", last_rdata, 32'h0000_00AA);

        // half store over zero
        op(1, 2'b01, 0, 32'h0E, 32'h5555_8001);
        op(0, 2'b10, 0, 32'h0C, 0);  chk("lw_after_sh", last_rdata, 32'h8001_0000);
        op(0, 2'b01, 0, 32'h0E, 0);  chk("lh", last_rdata, 32'hFFFF_8001);
        op(0, 2'b01, 1, 32'h0E, 0);  chk("lhu", last_rdata, 32'h0000_8001);

        // misaligned
        op(0, 2'b10, 0, 32'h02, 0);
        chk("mis_lw_err", {31'b0, last_err}, 32'd1);
        chk("mis_lw_rdata", last_rdata, 32'd0);
        chk("mis_lat", last_lat, 1);
        op(1, 2'b01, 0, 32'h11, 32'hFFFF_FFFF);
        chk("mis_sh_err", {31'b0, last_err}, 32'd1);
        op(0, 2'b10, 0, 32'h10, 0);  chk("mis_mem", last_rdata, 32'd0);
        op(0, 2'b11, 0, 32'h00, 0);  chk("size3_err", {31'b0, last_err}, 32'd1);

        // wrap / alias
        op(1, 2'b10, 0, 32'h1FC, 32'h1357_2468);
        op(0, 2'b10, 0, 32'hFC, 0);
        chk("wrap_val", last_rdata, 32'h1357_2468);
        chk("wrap_err", {31'b0, last_err}, 32'd0);

        // reset in the middle of a merge
        op(1, 2'b10, 0, 32'h20, 32'hCAFE_F00D);
        do_req(1, 2'b00, 0, 32'h21, 32'h77, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_wea", {31'b0, ram_wea}, 32'd0);
        chk("midrst_resp", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_addr", {26'b0, ram_addr}, 32'd0);
        op(0, 2'b10, 0, 32'h20, 0);
        chk("rst_no_commit", last_rdata, 32'hCAFE_F00D);

        // back-to-back with req_valid held
        start_acc = n_acc;
        do_req(1, 2'b00, 0, 32'h30, 32'h5A, 1'b1);
        do_req(0, 2'b10, 0, 32'h30, 0, 1'b1);
        do_req(1, 2'b10, 0, 32'h34, 32'h0102_0304, 1'b0);
        wait_idle();
        chk("b2b_accepts", n_acc - start_acc, 3);
        chk("b2b_lw", last_ld, 32'h0000_005A);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            logic [1:0]  rsz;
            logic [31:0] ra;
            rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra  = $urandom_range(0, 511);
            if ($urandom_range(0, 9) < 8) begin
                if (rsz == 2'd1) ra[0] = 1'b0;
                if (rsz == 2'd2) ra[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom,
                   1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 64; i++) chk("final_mem", ram[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
